// File: rtl/perf_counter_bank.sv
// perf_counter_bank: event counter bank with wrap/saturate modes, sticky overflow and snapshot readout
// Optional interrupt output enabled by defining PERFCNT_IRQ_EN.
module perf_counter_bank #(
   parameter int NUM_CNT  = 5,
   parameter int CNT_W    = 9,
   parameter int SAT_MODE = 0,
   parameter int ADDR_W   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cnt_en,
   input  logic [NUM_CNT-1:0]       events,
   input  logic                     clear,
   input  logic                     snap,
   input  logic [ADDR_W-1:0]        rd_addr,
`ifdef PERFCNT_IRQ_EN
   input  logic [NUM_CNT-1:0]       irq_mask,
   output logic                     irq,
`endif
   output logic [CNT_W-1:0]         rd_data,
   output logic                     rd_ovf,
   output logic [NUM_CNT-1:0]       ovf_flags,
   output logic [NUM_CNT*CNT_W-1:0] cnt_flat
);
   logic [CNT_W-1:0]   cnt_q [NUM_CNT];
   logic [CNT_W-1:0]   cnt_d [NUM_CNT];
   logic [CNT_W-1:0]   shd_q [NUM_CNT];
   logic [NUM_CNT-1:0] ovf_q, ovf_d, shd_ovf_q;
   logic [CNT_W-1:0]   rd_data_q, rd_data_d;
   logic               rd_ovf_q, rd_ovf_d;
   always_comb begin
      rd_data_d = '0;
      rd_ovf_d  = 1'b0;
      cnt_flat  = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         logic inc, top;
         inc = cnt_en & events[i];
         top = &cnt_q[i];
         cnt_d[i] = clear ? '0 :
                    !inc ? cnt_q[i] :
                    (top && SAT_MODE != 0) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
         ovf_d[i] = !clear & (ovf_q[i] | (inc & top));
         cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
         // out-of-range addresses match no channel and read as zero
         if (rd_addr == ADDR_W'(i)) begin
            rd_data_d = shd_q[i];
            rd_ovf_d  = shd_ovf_q[i];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= '0;
            shd_q[i] <= '0;
         end
         ovf_q     <= '0;
         shd_ovf_q <= '0;
         rd_data_q <= '0;
         rd_ovf_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= cnt_d[i];
            if (snap) shd_q[i] <= cnt_q[i];
         end
         ovf_q     <= ovf_d;
         if (snap) shd_ovf_q <= ovf_q;
         rd_data_q <= rd_data_d;
         rd_ovf_q  <= rd_ovf_d;
      end
   end
   assign ovf_flags = ovf_q;
   assign rd_data   = rd_data_q;
   assign rd_ovf    = rd_ovf_q;
`ifdef PERFCNT_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk) begin
      if (reset) irq_q <= 1'b0;
      else irq_q <= |(ovf_d & irq_mask);
   end
   assign irq = irq_q;
`endif
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed vector table on the wrap-mode bank plus hand sequences for saturate and irq
module tb_perf_counter_bank;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int errs = 0, checks = 0;

   logic       reset, cnt_en, clear, snap;
   logic [4:0] events;
   logic [3:0] rd_addr;
   logic [8:0] rd_data;
   logic       rd_ovf;
   logic [4:0] ovf_flags;
   logic [44:0] cnt_flat;

   logic        s_reset, s_en, s_clear, s_snap;
   logic [4:0]  s_events;
   logic [3:0]  s_addr;
   logic [3:0]  s_rd_data;
   logic        s_rd_ovf;
   logic [4:0]  s_ovf;
   logic [19:0] s_flat;

`ifdef PERFCNT_IRQ_EN
   logic [4:0] irq_mask, i_ovf;
   logic       irq, i_rd_ovf;
   logic [1:0] i_rd_data;
   logic [9:0] i_flat;
   logic       i_dummy;
   logic       w_irq, s_irq;
   assign i_dummy = 1'b0;
`endif

   perf_counter_bank u_wrap (
      .clk(clk), .reset(reset), .cnt_en(cnt_en), .events(events), .clear(clear), .snap(snap),
      .rd_addr(rd_addr),
`ifdef PERFCNT_IRQ_EN
      .irq_mask(5'b00000), .irq(w_irq),
`endif
      .rd_data(rd_data), .rd_ovf(rd_ovf), .ovf_flags(ovf_flags), .cnt_flat(cnt_flat));

   perf_counter_bank #(.CNT_W(4), .SAT_MODE(1)) u_sat (
      .clk(clk), .reset(s_reset), .cnt_en(s_en), .events(s_events), .clear(s_clear), .snap(s_snap),
      .rd_addr(s_addr),
`ifdef PERFCNT_IRQ_EN
      .irq_mask(5'b00000), .irq(s_irq),
`endif
      .rd_data(s_rd_data), .rd_ovf(s_rd_ovf), .ovf_flags(s_ovf), .cnt_flat(s_flat));

`ifdef PERFCNT_IRQ_EN
   perf_counter_bank #(.CNT_W(2)) u_irq (
      .clk(clk), .reset(s_reset), .cnt_en(s_en), .events(s_events), .clear(s_clear), .snap(i_dummy),
      .rd_addr(s_addr), .irq_mask(irq_mask), .irq(irq),
      .rd_data(i_rd_data), .rd_ovf(i_rd_ovf), .ovf_flags(i_ovf), .cnt_flat(i_flat));
`endif

   typedef struct {
      int         n;
      logic       rst, en, clr, snp;
      logic [4:0] ev;
      logic [3:0] ad;
      logic [44:0] ef;
      logic [4:0] eo;
      logic [8:0] er;
      logic       ero;
   } vec_t;
   vec_t tv[$];

   function automatic logic [44:0] fl(int a, int b, int c, int d, int e);
      return {9'(e), 9'(d), 9'(c), 9'(b), 9'(a)};
   endfunction

   task automatic add(int n, logic rst, logic en, logic [4:0] ev, logic clr, logic snp,
                      logic [3:0] ad, logic [44:0] ef, logic [4:0] eo, logic [8:0] er, logic ero);
      vec_t v;
      v.n = n; v.rst = rst; v.en = en; v.ev = ev; v.clr = clr; v.snp = snp;
      v.ad = ad; v.ef = ef; v.eo = eo; v.er = er; v.ero = ero;
      tv.push_back(v);
   endtask

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic sat_step(int n, logic en, logic [4:0] ev, logic clr);
      s_en = en; s_events = ev; s_clear = clr;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; cnt_en = 1'b0; events = '0; clear = 1'b0; snap = 1'b0; rd_addr = '0;
      s_reset = 1'b1; s_en = 1'b0; s_events = '0; s_clear = 1'b0; s_snap = 1'b0; s_addr = '0;
`ifdef PERFCNT_IRQ_EN
      irq_mask = 5'b00100;
`endif
      //   n   rst en ev       clr snp ad     flat                  ovf      rd    rov
      add(1,   1, 0, 5'b00000, 0, 0, 4'd0, fl(0,0,0,0,0),        5'b00000, 9'd0, 0);
      add(10,  0, 1, 5'b00001, 0, 0, 4'd0, fl(10,0,0,0,0),       5'b00000, 9'd0, 0);
      add(1,   1, 1, 5'b00001, 0, 0, 4'd0, fl(0,0,0,0,0),        5'b00000, 9'd0, 0);
      add(7,   0, 1, 5'b01000, 0, 0, 4'd0, fl(0,0,0,7,0),        5'b00000, 9'd0, 0);
      add(1,   0, 1, 5'b01000, 0, 1, 4'd0, fl(0,0,0,8,0),        5'b00000, 9'd0, 0);
      add(1,   0, 0, 5'b00000, 0, 0, 4'd3, fl(0,0,0,8,0),        5'b00000, 9'd7, 0);
      add(1,   0, 0, 5'b00000, 0, 0, 4'd7, fl(0,0,0,8,0),        5'b00000, 9'd0, 0);
      add(42,  0, 1, 5'b00001, 0, 0, 4'd0, fl(42,0,0,8,0),       5'b00000, 9'd0, 0);
      add(1,   0, 1, 5'b11111, 1, 1, 4'd0, fl(0,0,0,0,0),        5'b00000, 9'd0, 0);
      add(1,   0, 0, 5'b00000, 0, 0, 4'd0, fl(0,0,0,0,0),        5'b00000, 9'd42, 0);
      add(1,   0, 0, 5'b00000, 0, 0, 4'd3, fl(0,0,0,0,0),        5'b00000, 9'd8, 0);
      add(5,   0, 0, 5'b11111, 0, 0, 4'd3, fl(0,0,0,0,0),        5'b00000, 9'd8, 0);
      add(511, 0, 1, 5'b00100, 0, 0, 4'd3, fl(0,0,511,0,0),      5'b00000, 9'd8, 0);
      add(1,   0, 1, 5'b00100, 0, 0, 4'd3, fl(0,0,0,0,0),        5'b00100, 9'd8, 0);
      add(1,   0, 1, 5'b00100, 0, 0, 4'd3, fl(0,0,1,0,0),        5'b00100, 9'd8, 0);
      add(1,   0, 0, 5'b00000, 0, 1, 4'd3, fl(0,0,1,0,0),        5'b00100, 9'd8, 0);
      add(1,   0, 0, 5'b00000, 0, 0, 4'd2, fl(0,0,1,0,0),        5'b00100, 9'd1, 1);
      add(1,   0, 0, 5'b00000, 1, 0, 4'd2, fl(0,0,0,0,0),        5'b00000, 9'd1, 1);
      add(1,   1, 0, 5'b00000, 0, 0, 4'd2, fl(0,0,0,0,0),        5'b00000, 9'd0, 0);
      add(3,   0, 1, 5'b10011, 0, 0, 4'd0, fl(3,3,0,0,3),        5'b00000, 9'd0, 0);

      for (int k = 0; k < tv.size(); k++) begin
         reset = tv[k].rst; cnt_en = tv[k].en; events = tv[k].ev;
         clear = tv[k].clr; snap = tv[k].snp; rd_addr = tv[k].ad;
         repeat (tv[k].n) @(posedge clk);
         #1;
         chk($sformatf("v%0d cnt_flat", k), 64'(cnt_flat), 64'(tv[k].ef));
         chk($sformatf("v%0d ovf_flags", k), 64'(ovf_flags), 64'(tv[k].eo));
         chk($sformatf("v%0d rd_data", k), 64'(rd_data), 64'(tv[k].er));
         chk($sformatf("v%0d rd_ovf", k), 64'(rd_ovf), 64'(tv[k].ero));
      end

      @(posedge clk); #1;
      s_reset = 1'b0;
      chk("sat reset flat", 64'(s_flat), 64'd0);
      sat_step(15, 1, 5'b00010, 0);
      chk("sat 15 value", 64'(s_flat), 64'h000f0);
      chk("sat 15 ovf", 64'(s_ovf), 64'd0);
      sat_step(5, 1, 5'b00010, 0);
      chk("sat 20 value", 64'(s_flat), 64'h000f0);
      chk("sat 20 ovf", 64'(s_ovf), 64'b00010);
`ifdef PERFCNT_IRQ_EN
      chk("irq ch2 unaffected", 64'(irq), 64'd0);
`endif
      sat_step(1, 1, 5'b00010, 1);
      chk("sat clear value", 64'(s_flat), 64'd0);
      chk("sat clear ovf", 64'(s_ovf), 64'd0);
`ifdef PERFCNT_IRQ_EN
      sat_step(3, 1, 5'b00100, 0);
      chk("irq pre-ovf", 64'(irq), 64'd0);
      chk("irq pre-ovf val", 64'(i_flat), 64'h030);
      sat_step(1, 1, 5'b00100, 0);
      chk("irq ovf flag", 64'(i_ovf), 64'b00100);
      chk("irq rises", 64'(irq), 64'd1);
      sat_step(1, 0, 5'b00000, 1);
      chk("irq clear", 64'(irq), 64'd0);
      sat_step(4, 1, 5'b00001, 0);
      chk("irq masked ovf", 64'(i_ovf), 64'b00001);
      chk("irq masked", 64'(irq), 64'd0);
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised bank of event counters for the pipelined RISC-V core. It replaces the fixed 9-bit jump/memory/cycle/instruction counters. Each channel counts a one-cycle event pulse from the core, with a selectable wrap or saturate mode and sticky overflow flags. A snapshot/shadow register set gives coherent readout while live counts keep running. Sits beside the core; live values also feed the board hex displays.

Parameters:
NUM_CNT, 5, number of counter channels (1..16)
CNT_W, 9, width of each counter in bits (2..32)
SAT_MODE, 0, 0 = counters wrap to 0 past max; 1 = counters hold at all-ones
ADDR_W, 4, width of read address; must satisfy 2**ADDR_W >= NUM_CNT

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
cnt_en  input  1  global count enable; events ignored when 0
events  input  NUM_CNT  per-channel event pulse; bit i = 1 increments channel i by 1 this cycle
clear  input  1  synchronous clear of all live counters and overflow flags
snap  input  1  copy all live counters and flags into shadow registers
rd_addr  input  ADDR_W  shadow channel select
rd_data  output  CNT_W  registered shadow count of channel rd_addr
rd_ovf  output  1  registered shadow overflow flag of channel rd_addr
ovf_flags  output  NUM_CNT  live sticky overflow flags
cnt_flat  output  NUM_CNT*CNT_W  live counters; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (reset=1 at posedge): all live counters, shadows, ovf_flags, rd_data and rd_ovf = 0. Reset overrides every other input.
- Priority per cycle: reset > clear > increment. clear=1 zeroes live counters and ovf_flags. Any event in that cycle is dropped.
- Increment: channel i updates when cnt_en=1, events[i]=1, clear=0. Live value is visible on cnt_flat 1 cycle after the event edge.
- All channels count independently; several may increment in the same cycle.
- Wrap mode (SAT_MODE=0): at value 2**CNT_W-1 an event makes the value 0 and sets ovf_flags[i].
- Saturate mode (SAT_MODE=1): at all-ones an event holds the value and sets ovf_flags[i].
- ovf_flags bits are sticky until clear or reset.
- Snap: snap=1 loads shadow[i] with the live counter value before any same-cycle update. Shadow flags likewise take the pre-update flags.
  - snap+clear in the same cycle: shadow gets the pre-clear values.
  - snap+event in the same cycle: shadow gets the pre-increment value.
- Shadows hold until the next snap or reset.
- Readout: rd_data/rd_ovf are registered with 1-cycle latency from rd_addr.
  - They reflect shadow contents as of the previous edge, so a read in the cycle after snap returns the new shadow.
  - rd_addr >= NUM_CNT returns rd_data=0, rd_ovf=0.
- No combinational path from events to any output.

Optional Feature:
PERFCNT_IRQ_EN.
- Defined: adds input irq_mask (NUM_CNT) and output irq (1). irq is registered: irq <= |(ovf_flags_next & irq_mask). It asserts the cycle ovf_flags shows the flag and stays high until clear or reset (reset value 0). irq_mask changes take effect 1 cycle later.
- Undefined: neither port exists and no interrupt logic is generated.

Test Plan:
- Reset then 10 cycles with cnt_en=1, events=5'b00001 -> cnt_flat channel 0 = 10, others 0, ovf_flags=0. Assert reset mid-count -> all outputs 0 next cycle.
- Wrap mode, CNT_W=9: 512 events on channel 2 -> value 0, ovf_flags[2]=1. One more event -> value 1, flag still 1.
- SAT_MODE=1, CNT_W=4: 20 events on channel 1 -> value 15, ovf_flags[1]=1. clear -> value 0, flag 0.
- Channel 3 at 7: snap + event same cycle -> live 8. rd_addr=3 next cycle -> rd_data=7 one cycle later. rd_addr=7 (NUM_CNT=5) -> rd_data=0, rd_ovf=0.
- clear+event+snap same cycle with channel 0 at 42 -> live 0, shadow 42. cnt_en=0 with events=all-ones for 5 cycles -> no change.
- PERFCNT_IRQ_EN, irq_mask=5'b00100, CNT_W=2: 4 events on channel 2 -> irq=1 on the cycle ovf_flags[2] rises. Overflow on channel 0 alone -> irq stays 0. clear -> irq=0.
